uart_fifo_ctrl: RTL and testbench
=================================

Name: uart_fifo_ctrl

Overview:
Byte-buffering stage between the peripheral bus register logic and the UART core (UART_tx/UART_rx). A TX FIFO accepts bytes from the bus side and launches them into the transmitter with a trmt pulse. An RX FIFO captures bytes from the receiver and clears the receiver's ready flag. The block decouples software from bit-time pacing and flags receive overruns.

Parameters:
DEPTH, 16, entries per FIFO; power of two, minimum 2.
AW, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tx_wr_en  in  1  push tx_wr_data into TX FIFO
tx_wr_data  in  8  byte to queue for transmission
tx_full  out  1  TX FIFO holds DEPTH entries
tx_count  out  AW+1  TX FIFO occupancy
uart_trmt  out  1  one-cycle launch pulse to transmitter
uart_tx_data  out  8  byte presented with uart_trmt, held until next launch
uart_tx_ready  in  1  transmitter idle and able to accept trmt
uart_tx_done  in  1  transmitter finished current byte
uart_rx_rdy  in  1  receiver holds a byte (level, until cleared)
uart_rx_data  in  8  received byte
uart_clr_rx_rdy  out  1  one-cycle clear pulse to receiver
rx_rd_en  in  1  pop head of RX FIFO
rx_rd_data  out  8  RX FIFO head (first-word fall-through)
rx_empty  out  1  RX FIFO holds no entries
rx_count  out  AW+1  RX FIFO occupancy
rx_overrun  out  1  sticky: received byte dropped because RX FIFO full
clr_overrun  in  1  clears rx_overrun

Behaviour:
- Reset (async, rst_n=0): both FIFOs empty, pointers 0, counts 0, tx_full=0, rx_empty=1, uart_trmt=0, uart_tx_data=8'h00, uart_clr_rx_rdy=0, rx_overrun=0, both FSMs in idle state. rx_rd_data is don't-care while rx_empty=1.
- Mid-operation reset discards all queued bytes. No trmt or clear pulse may be issued in the cycle after deassertion.
- FIFO storage: circular buffer with AW-bit wrapping pointers; occupancy counter of AW+1 bits; full = (count==DEPTH).
- Full and empty are evaluated on the registered count at the start of a cycle.
- TX push while tx_full=1: byte dropped, no state change, even if a pop occurs in the same cycle.
- Simultaneous push and pop with count between 1 and DEPTH-1: count unchanged, both pointers advance.
- TX FSM states:
  - TX_IDLE: if TX FIFO non-empty and uart_tx_ready=1, then register head into uart_tx_data, assert uart_trmt for exactly one cycle, pop the FIFO, go to TX_WAIT.
  - TX_WAIT: stay until uart_tx_done=1, then go to TX_IDLE.
- A new launch additionally requires uart_tx_ready=1, so a level-type tx_done cannot cause a double launch.
- TX latency: a byte written at edge N into an empty FIFO, with the transmitter ready, produces uart_trmt=1 in the cycle following edge N+1, i.e. one cycle after tx_count shows 1.
- RX FSM states:
  - RX_IDLE: if uart_rx_rdy=1, then push uart_rx_data into the RX FIFO (if not full, else set rx_overrun), assert uart_clr_rx_rdy for one cycle, go to RX_CLR.
  - RX_CLR: ignore uart_rx_rdy for one cycle (receiver clear takes effect), then go to RX_IDLE.
- Each received byte is captured exactly once.
- RX pop while rx_empty=1: ignored.
- RX capture and rx_rd_en in the same cycle with the FIFO full: capture dropped, overrun set, pop performed.
- rx_overrun: set when a capture is dropped; cleared by clr_overrun. If set and clear occur in the same cycle, set wins.
- tx_count and rx_count update on the same edge as the push or pop. All outputs are registered or derived directly from registers.

Test Plan:
- Single byte: write 8'hA5 with tx_uart_ready=1 → one uart_trmt pulse carrying uart_tx_data=8'hA5, tx_count returns to 0, no further trmt until uart_tx_done.
- Burst: write 8'h01..8'h10 back-to-back (DEPTH=16) → tx_full=1 after 16th write; a 17th write (8'hFF) is dropped; the transmitter model receives 01..10 in order with exactly one trmt per tx_done.
- TX wrap: interleave 40 writes and launches so the pointers wrap twice → byte order preserved, counts never exceed 16.
- RX capture: pulse uart_rx_rdy level with data 8'h3C, held until clear → exactly one uart_clr_rx_rdy pulse, rx_count=1, rx_rd_data=8'h3C; rx_rd_en → rx_empty=1.
- RX overrun: deliver 17 bytes without reads → 17th dropped, rx_overrun=1, first 16 read back intact. Assert clr_overrun together with a new dropped byte → rx_overrun stays 1.
- Reset mid-transfer: with 5 TX bytes queued and the FSM in TX_WAIT, pulse rst_n low → counts 0, uart_trmt=0, no launch after release until a new write.

Source files
------------

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl
// Byte buffering between the bus register logic and the UART core.
// The TX FIFO queues bus writes and launches each byte into the
// transmitter with a one-cycle uart_trmt pulse. The RX FIFO captures
// bytes from the receiver, acknowledges each with uart_clr_rx_rdy and
// flags dropped captures with a sticky rx_overrun.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   tx_wr_en, tx_wr_data           push a byte into the TX FIFO
//   tx_full, tx_count              TX FIFO status
//   uart_trmt, uart_tx_data        launch pulse and byte to transmitter
//   uart_tx_ready, uart_tx_done    transmitter idle / byte finished
//   uart_rx_rdy, uart_rx_data      receiver holds a byte (level) and data
//   uart_clr_rx_rdy                one-cycle clear pulse to receiver
//   rx_rd_en, rx_rd_data           pop / first-word fall-through head
//   rx_empty, rx_count             RX FIFO status
//   rx_overrun, clr_overrun        sticky drop flag and its clear
//
// TX FSM
//   state   | meaning
//   TX_IDLE | waiting for a queued byte and a ready transmitter
//   TX_WAIT | byte launched, waiting for uart_tx_done
// RX FSM
//   state   | meaning
//   RX_IDLE | waiting for uart_rx_rdy
//   RX_CLR  | clear pulse issued, rx_rdy still high this cycle; ignore it

module uart_fifo_ctrl #(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tx_wr_en,
    input  logic [7:0]    tx_wr_data,
    output logic          tx_full,
    output logic [AW:0]   tx_count,
    output logic          uart_trmt,
    output logic [7:0]    uart_tx_data,
    input  logic          uart_tx_ready,
    input  logic          uart_tx_done,
    input  logic          uart_rx_rdy,
    input  logic [7:0]    uart_rx_data,
    output logic          uart_clr_rx_rdy,
    input  logic          rx_rd_en,
    output logic [7:0]    rx_rd_data,
    output logic          rx_empty,
    output logic [AW:0]   rx_count,
    output logic          rx_overrun,
    input  logic          clr_overrun
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {TX_IDLE, TX_WAIT} tx_state_t;
    typedef enum logic {RX_IDLE, RX_CLR}  rx_state_t;

    tx_state_t tx_state, tx_state_nxt;
    rx_state_t rx_state, rx_state_nxt;

    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [AW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;

    logic tx_launch, tx_push;
    logic rx_capture, rx_push, rx_drop, rx_pop;

    assign tx_full    = (tx_count == FULL_CNT);
    assign rx_empty   = (rx_count == '0);
    assign rx_rd_data = rx_mem[rx_rd_ptr];

    // A push into a full FIFO is dropped even if a launch frees a slot
    // in the same cycle: fullness is judged on the registered count.
    assign tx_push = tx_wr_en && !tx_full;
    assign rx_push = rx_capture && (rx_count != FULL_CNT);
    assign rx_drop = rx_capture && (rx_count == FULL_CNT);
    assign rx_pop  = rx_rd_en && !rx_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            rx_state <= RX_IDLE;
        end else begin
            tx_state <= tx_state_nxt;
            rx_state <= rx_state_nxt;
        end
    end

    // Launch requires uart_tx_ready as well as TX_IDLE, so a tx_done that
    // is a level rather than a pulse cannot trigger a second launch.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_launch    = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if ((tx_count != '0) && uart_tx_ready) begin
                    tx_launch    = 1'b1;
                    tx_state_nxt = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (uart_tx_done) tx_state_nxt = TX_IDLE;
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_capture   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (uart_rx_rdy) begin
                    rx_capture   = 1'b1;
                    rx_state_nxt = RX_CLR;
                end
            end
            RX_CLR:  rx_state_nxt = RX_IDLE;
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= tx_wr_data;
        if (rx_push) rx_mem[rx_wr_ptr] <= uart_rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr    <= '0;
            tx_rd_ptr    <= '0;
            tx_count     <= '0;
            uart_trmt    <= 1'b0;
            uart_tx_data <= 8'h00;
        end else begin
            uart_trmt <= tx_launch;
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_launch) begin
                tx_rd_ptr    <= tx_rd_ptr + 1'b1;
                uart_tx_data <= tx_mem[tx_rd_ptr];
            end
            case ({tx_push, tx_launch})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr       <= '0;
            rx_rd_ptr       <= '0;
            rx_count        <= '0;
            uart_clr_rx_rdy <= 1'b0;
            rx_overrun      <= 1'b0;
        end else begin
            uart_clr_rx_rdy <= rx_capture;
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (rx_drop)          rx_overrun <= 1'b1;
            else if (clr_overrun) rx_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
module tb_uart_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_wr_en = 1'b0;
    logic [7:0] tx_wr_data = 8'h00;
    logic       tx_full;
    logic [4:0] tx_count;
    logic       uart_trmt;
    logic [7:0] uart_tx_data;
    logic       uart_tx_ready;
    logic       uart_tx_done;
    logic       uart_rx_rdy = 1'b0;
    logic [7:0] uart_rx_data = 8'h00;
    logic       uart_clr_rx_rdy;
    logic       rx_rd_en = 1'b0;
    logic [7:0] rx_rd_data;
    logic       rx_empty;
    logic [4:0] rx_count;
    logic       rx_overrun;
    logic       clr_overrun = 1'b0;

    int checks = 0;
    int errors = 0;

    // transmitter: manual (table-driven) or automatic model
    logic auto_mode = 1'b0;
    logic t_ready = 1'b0, t_done = 1'b0;
    logic m_ready = 1'b1, m_done = 1'b0;
    int   m_cnt = 0;
    int   dbl_launch = 0;
    int   trmt_cnt = 0;
    int   clr_cnt = 0;
    int   cnt_ovf = 0;
    logic [7:0] sent_q[$];

    assign uart_tx_ready = auto_mode ? m_ready : t_ready;
    assign uart_tx_done  = auto_mode ? m_done  : t_done;

    uart_fifo_ctrl #(.DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data),
        .tx_full(tx_full), .tx_count(tx_count),
        .uart_trmt(uart_trmt), .uart_tx_data(uart_tx_data),
        .uart_tx_ready(uart_tx_ready), .uart_tx_done(uart_tx_done),
        .uart_rx_rdy(uart_rx_rdy), .uart_rx_data(uart_rx_data),
        .uart_clr_rx_rdy(uart_clr_rx_rdy),
        .rx_rd_en(rx_rd_en), .rx_rd_data(rx_rd_data),
        .rx_empty(rx_empty), .rx_count(rx_count),
        .rx_overrun(rx_overrun), .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (uart_trmt) begin
            trmt_cnt++;
            sent_q.push_back(uart_tx_data);
        end
        if (uart_clr_rx_rdy) clr_cnt++;
        if (tx_count > 5'd16 || rx_count > 5'd16) cnt_ovf++;
        m_done = 1'b0;
        if (!auto_mode) begin
            m_ready = 1'b1;
            m_cnt   = 0;
        end else if (uart_trmt) begin
            if (!m_ready) dbl_launch++;
            m_ready = 1'b0;
            m_cnt   = 3;
        end else if (m_cnt == 1) begin
            m_done  = 1'b1;
            m_ready = 1'b1;
            m_cnt   = 0;
        end else if (m_cnt != 0) begin
            m_cnt--;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tx_wr_en = 1'b0; uart_rx_rdy = 1'b0; rx_rd_en = 1'b0;
        clr_overrun = 1'b0; t_ready = 1'b0; t_done = 1'b0; auto_mode = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Receiver model: holds rx_rdy until the clear pulse appears.
    task automatic deliver(input logic [7:0] b, input logic co, input logic rd);
        @(negedge clk);
        uart_rx_rdy = 1'b1; uart_rx_data = b; clr_overrun = co; rx_rd_en = rd;
        @(negedge clk);
        clr_overrun = 1'b0; rx_rd_en = 1'b0;
        chk("rx_clr_pulse", uart_clr_rx_rdy, 1);
        uart_rx_rdy = 1'b0;
    endtask

    task automatic wait_sent(input int n);
        for (int k = 0; k < 1000 && sent_q.size() < n; k++) @(negedge clk);
        chk("tx_sent_count", sent_q.size(), n);
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] wd;
        logic       rdy;
        logic       done;
        logic       rxr;
        logic [7:0] rxd;
        logic       rd;
        logic [4:0] e_txc;
        logic       e_trmt;
        logic [7:0] e_txd;
        logic [4:0] e_rxc;
        logic       e_clr;
        logic [7:0] e_head;
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];

    initial begin
        int n;
        int clr_base;

        //          wr    wd      rdy   done  rxr   rxd     rd    txc    trmt  txd     rxc    clr   head
        vt[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 8'h00, 5'd0, 1'b0, 8'h00};
        vt[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 8'hA5, 5'd0, 1'b0, 8'h00};
        vt[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'hA5, 5'd0, 1'b0, 8'h00};
        vt[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'hA5, 5'd0, 1'b0, 8'h00};
        vt[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'hA5, 5'd0, 1'b0, 8'h00};
        vt[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 5'd0, 1'b0, 8'hA5, 5'd1, 1'b1, 8'h3C};
        vt[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 5'd0, 1'b0, 8'hA5, 5'd1, 1'b0, 8'h3C};
        vt[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'hA5, 5'd1, 1'b0, 8'h3C};
        vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'hA5, 5'd0, 1'b0, 8'h00};
        vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 8'hA5, 5'd0, 1'b0, 8'h00};
        vt[10] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 8'hA5, 5'd0, 1'b0, 8'h00};
        vt[11] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 5'd1, 1'b1, 8'h11, 5'd0, 1'b0, 8'h00};
        vt[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 8'h11, 5'd0, 1'b0, 8'h00};
        vt[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 8'h11, 5'd0, 1'b0, 8'h00};
        vt[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 8'h22, 5'd0, 1'b0, 8'h00};
        vt[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h22, 5'd0, 1'b0, 8'h00};
        vt[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 8'h22, 5'd0, 1'b0, 8'h00};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_tx_count", tx_count, 0);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_trmt", uart_trmt, 0);
        chk("rst_tx_data", uart_tx_data, 8'h00);
        chk("rst_rx_empty", rx_empty, 1);
        chk("rst_rx_count", rx_count, 0);
        chk("rst_clr", uart_clr_rx_rdy, 0);
        chk("rst_overrun", rx_overrun, 0);
        rst_n = 1'b1;

        // table: single byte, level tx_done, RX capture/pop, push+launch
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            tx_wr_en = vt[i].wr; tx_wr_data = vt[i].wd;
            t_ready = vt[i].rdy; t_done = vt[i].done;
            uart_rx_rdy = vt[i].rxr; uart_rx_data = vt[i].rxd;
            rx_rd_en = vt[i].rd;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_tx_count", i), tx_count, vt[i].e_txc);
            chk($sformatf("v%0d_trmt", i), uart_trmt, vt[i].e_trmt);
            chk($sformatf("v%0d_tx_data", i), uart_tx_data, vt[i].e_txd);
            chk($sformatf("v%0d_rx_count", i), rx_count, vt[i].e_rxc);
            chk($sformatf("v%0d_rx_empty", i), rx_empty, (vt[i].e_rxc == 5'd0) ? 1 : 0);
            chk($sformatf("v%0d_clr", i), uart_clr_rx_rdy, vt[i].e_clr);
            if (vt[i].e_rxc != 5'd0)
                chk($sformatf("v%0d_rx_head", i), rx_rd_data, vt[i].e_head);
        end
        @(negedge clk);
        tx_wr_en = 1'b0; uart_rx_rdy = 1'b0; rx_rd_en = 1'b0;

        // burst to full, dropped 17th write, then drain through the model
        do_reset();
        sent_q.delete();
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            tx_wr_en = 1'b1; tx_wr_data = 8'(i);
        end
        @(negedge clk);
        chk("burst_full", tx_full, 1);
        chk("burst_count16", tx_count, 16);
        tx_wr_data = 8'hFF;
        @(negedge clk);
        tx_wr_en = 1'b0;
        chk("burst_drop_count", tx_count, 16);
        auto_mode = 1'b1;
        wait_sent(16);
        for (int i = 0; i < 16 && i < sent_q.size(); i++)
            chk($sformatf("burst_byte%0d", i), sent_q[i], i + 1);
        repeat (20) @(negedge clk);
        chk("burst_no_extra", sent_q.size(), 16);
        chk("burst_empty", tx_count, 0);

        // 40 writes throttled by tx_full so both pointers wrap
        sent_q.delete();
        n = 0;
        for (int k = 0; k < 2000 && n < 40; k++) begin
            @(negedge clk);
            if (!tx_full) begin
                tx_wr_en = 1'b1; tx_wr_data = 8'(8'h80 + n); n++;
            end else begin
                tx_wr_en = 1'b0;
            end
        end
        @(negedge clk);
        tx_wr_en = 1'b0;
        chk("wrap_written", n, 40);
        wait_sent(40);
        for (int i = 0; i < 40 && i < sent_q.size(); i++)
            chk($sformatf("wrap_byte%0d", i), sent_q[i], 8'h80 + i);
        chk("double_launch", dbl_launch, 0);
        auto_mode = 1'b0;

        // RX overrun and overrun-clear priority
        do_reset();
        clr_base = clr_cnt;
        for (int i = 0; i < 17; i++) deliver(8'(8'h40 + i), 1'b0, 1'b0);
        chk("ovr_count16", rx_count, 16);
        chk("ovr_set", rx_overrun, 1);
        chk("ovr_head", rx_rd_data, 8'h40);
        @(negedge clk);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        chk("ovr_cleared", rx_overrun, 0);
        deliver(8'hEF, 1'b1, 1'b0);
        chk("ovr_set_wins", rx_overrun, 1);
        chk("ovr_count_hold", rx_count, 16);
        @(negedge clk);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        deliver(8'h99, 1'b0, 1'b1);
        chk("ovr_pop_full_count", rx_count, 15);
        chk("ovr_pop_full_flag", rx_overrun, 1);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("rx_byte%0d", i), rx_rd_data, 8'h41 + i);
            rx_rd_en = 1'b1;
            @(negedge clk);
        end
        rx_rd_en = 1'b0;
        chk("rx_drained", rx_empty, 1);
        chk("rx_clr_pulses", clr_cnt - clr_base, 19);

        // reset while in TX_WAIT with 5 bytes still queued
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tx_wr_en = 1'b1; tx_wr_data = 8'(8'hC0 + i);
        end
        @(negedge clk);
        tx_wr_en = 1'b0; t_ready = 1'b1;
        @(negedge clk);
        t_ready = 1'b0;
        chk("mid_launch", uart_trmt, 1);
        chk("mid_count5", tx_count, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_count", tx_count, 0);
        chk("mid_rst_trmt", uart_trmt, 0);
        @(negedge clk);
        rst_n = 1'b1; t_ready = 1'b1; t_done = 1'b1;
        n = trmt_cnt;
        repeat (10) @(negedge clk);
        chk("mid_no_launch", trmt_cnt - n, 0);
        chk("mid_count0", tx_count, 0);
        tx_wr_en = 1'b1; tx_wr_data = 8'h5A;
        @(negedge clk);
        tx_wr_en = 1'b0;
        chk("mid_new_count", tx_count, 1);
        @(negedge clk);
        chk("mid_new_trmt", uart_trmt, 1);
        chk("mid_new_data", uart_tx_data, 8'h5A);

        chk("count_bound", cnt_ovf, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
